// File: rtl/wm8731_config_sequencer_pkg.sv
// Shared types and the fixed WM8731 register-initialisation table.
package wm8731_pkg;

    localparam int NUM_REGS = 11;

    typedef struct packed {
        logic [6:0] regno;
        logic [8:0] data;
    } reg_write_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_REQ,
        ST_WAIT_ACK,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Codec reset first, active last so the codec never runs half-configured.
    localparam reg_write_t CONFIG_TABLE [NUM_REGS] = '{
        '{regno: 7'd15, data: 9'h000},
        '{regno: 7'd0,  data: 9'h017},
        '{regno: 7'd1,  data: 9'h017},
        '{regno: 7'd2,  data: 9'h079},
        '{regno: 7'd3,  data: 9'h079},
        '{regno: 7'd4,  data: 9'h012},
        '{regno: 7'd5,  data: 9'h000},
        '{regno: 7'd6,  data: 9'h000},
        '{regno: 7'd7,  data: 9'h002},
        '{regno: 7'd8,  data: 9'h000},
        '{regno: 7'd9,  data: 9'h001}
    };

    // WM8731 control word: first byte carries the register number and data bit 8.
    function automatic logic [1:0][7:0] pack_write(input reg_write_t w);
        return {w.regno, w.data};
    endfunction

endpackage

// File: rtl/wm8731_config_sequencer_rom.sv
// Combinational table lookup: entry index to packed two-byte codec write.
module wm8731_config_rom
    import wm8731_pkg::*;
(
    input  logic [3:0]      index,
    output logic [1:0][7:0] wdata
);

    always_comb begin
        wdata = '0;
        if (index < 4'(NUM_REGS)) begin
            wdata = pack_write(CONFIG_TABLE[index]);
        end
    end

endmodule

// File: rtl/wm8731_config_sequencer.sv
// Walks the WM8731 init table, one I2C write per req/ack handshake, and
// reports done or ack-timeout error upstream.
module wm8731_config_sequencer
    import wm8731_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR       = 7'h1A,
    parameter int         GAP_CYCLES     = 2400,
    parameter int         TIMEOUT_CYCLES = 240000,
    parameter bit         AUTO_START     = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            en,
    input  logic            ack,
    output logic            req,
    output logic [6:0]      addr,
    output logic [1:0][7:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic [3:0]      index
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int GAP_W   = $clog2(GAP_CYCLES) + 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

    state_t               state, state_next;
    logic [3:0]           index_next;
    logic                 req_next;
    logic [6:0]           addr_next;
    logic [1:0][7:0]      wdata_next;
    logic                 busy_next;
    logic                 done_next;
    logic                 error_next;
    logic [TIMER_W-1:0]   timer, timer_next;
    logic [GAP_W-1:0]     gap_cnt, gap_next;
    logic                 pending, pending_next;
    logic                 start_q;
    logic [1:0][7:0]      rom_wdata;

    wm8731_config_rom u_rom (
        .index (index),
        .wdata (rom_wdata)
    );

    // pending comes out of reset set, so the autostart fires on the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            index   <= '0;
            req     <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            timer   <= '0;
            gap_cnt <= '0;
            pending <= AUTO_START;
            start_q <= 1'b0;
        end else begin
            state   <= state_next;
            index   <= index_next;
            req     <= req_next;
            addr    <= addr_next;
            wdata   <= wdata_next;
            busy    <= busy_next;
            done    <= done_next;
            error   <= error_next;
            timer   <= timer_next;
            gap_cnt <= gap_next;
            pending <= pending_next;
            start_q <= start;
        end
    end

    always_comb begin
        state_next   = state;
        index_next   = index;
        req_next     = req;
        addr_next    = addr;
        wdata_next   = wdata;
        busy_next    = busy;
        done_next    = done;
        error_next   = error;
        timer_next   = timer;
        gap_next     = gap_cnt;
        pending_next = pending;

        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                // start is only honoured here; pulses while busy are dropped.
                if (start_q || (state == ST_IDLE && pending)) begin
                    state_next   = ST_LOAD;
                    index_next   = '0;
                    busy_next    = 1'b1;
                    done_next    = 1'b0;
                    error_next   = 1'b0;
                    pending_next = 1'b0;
                end
            end

            ST_LOAD: begin
                addr_next  = DEV_ADDR;
                wdata_next = rom_wdata;
                req_next   = 1'b1;
                state_next = ST_REQ;
            end

            ST_REQ: begin
                if (en) begin
                    req_next   = 1'b0;
                    timer_next = '0;
                    state_next = ST_WAIT_ACK;
                end
            end

            ST_WAIT_ACK: begin
                // ack wins over a timeout landing in the same cycle.
                if (ack) begin
                    if (index == 4'(NUM_REGS - 1)) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                    end else begin
                        gap_next   = '0;
                        state_next = ST_GAP;
                    end
                end else if (timer == TIMER_LAST) begin
                    state_next = ST_ERROR;
                    error_next = 1'b1;
                    busy_next  = 1'b0;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end

            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    index_next = index + 1'b1;
                    state_next = ST_LOAD;
                end else begin
                    gap_next = gap_cnt + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
